// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: IF/ID/EX/MEM/WB/MDUW/EXC one-hot sequencing with memory timeout.
// Optional exception state enabled by defining MC_CTRL_EXC_EN.
module mc_ctrl_fsm #(
  parameter int unsigned          NUM_INSTR   = 54,
  parameter logic [NUM_INSTR-1:0] JR_MASK     = NUM_INSTR'(1) << 16,
  parameter logic [NUM_INSTR-1:0] MDU_MASK    = '0,
  parameter logic [NUM_INSTR-1:0] LOAD_MASK   = '0,
  parameter logic [NUM_INSTR-1:0] STORE_MASK  = '0,
  parameter logic [NUM_INSTR-1:0] WB_MASK     = NUM_INSTR'(1),
  parameter int unsigned          MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_INSTR-1:0] decoded_instr,
  input  logic                 mem_ready,
  input  logic                 mdu_busy,
  input  logic                 exc_req,
  output logic [6:0]           state,
  output logic                 pc_ena,
  output logic                 ir_in,
  output logic                 decode_ena,
  output logic                 zin,
  output logic                 zout,
  output logic                 npc_in,
  output logic                 alu_ena,
  output logic                 mdu_start,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 regfile_w,
  output logic                 bus_err,
  output logic                 exc_ack,
  output logic                 instr_done
);

  typedef enum logic [6:0] {
    S_IF   = 7'b0000001,
    S_ID   = 7'b0000010,
    S_EX   = 7'b0000100,
    S_MEM  = 7'b0001000,
    S_WB   = 7'b0010000,
    S_MDUW = 7'b0100000,
    S_EXC  = 7'b1000000
  } state_t;

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] mem_cnt;
  logic          mem_timeout;

  logic raw_jr, raw_mdu, raw_load, raw_store;
  logic is_jr, is_mdu, is_load, is_store, is_wb;

  assign raw_jr    = |(decoded_instr & JR_MASK);
  assign raw_mdu   = |(decoded_instr & MDU_MASK);
  assign raw_load  = |(decoded_instr & LOAD_MASK);
  assign raw_store = |(decoded_instr & STORE_MASK);
  assign is_wb     = |(decoded_instr & WB_MASK);

  // Overlapping class masks resolve JR > MDU > LOAD > STORE.
  assign is_jr    = raw_jr;
  assign is_mdu   = raw_mdu & ~raw_jr;
  assign is_load  = raw_load & ~raw_jr & ~raw_mdu;
  assign is_store = raw_store & ~raw_jr & ~raw_mdu & ~raw_load;

  always_comb begin
    state_d     = S_IF;
    mem_timeout = 1'b0;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (is_jr) state_d = S_IF;
        else       state_d = S_EX;
`ifdef MC_CTRL_EXC_EN
        if (exc_req) state_d = S_EXC;
`endif
      end
      S_EX: begin
        if (is_mdu)                   state_d = S_MDUW;
        else if (is_load || is_store) state_d = S_MEM;
        else if (is_wb)               state_d = S_WB;
        else                          state_d = S_IF;
      end
      S_MDUW: begin
        if (mdu_busy)   state_d = S_MDUW;
        else if (is_wb) state_d = S_WB;
        else            state_d = S_IF;
      end
      S_MEM: begin
        // A completing request wins over a timeout landing on the same cycle.
        if (mem_ready) begin
          state_d = is_load ? S_WB : S_IF;
        end else if (mem_cnt == CW'(MEM_TIMEOUT - 1)) begin
          mem_timeout = 1'b1;
`ifdef MC_CTRL_EXC_EN
          state_d = S_EXC;
`else
          state_d = S_IF;
`endif
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_IF;
      S_EXC:   state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      mem_cnt <= '0;
    end else begin
      state_q <= state_d;
      mem_cnt <= (state_q == S_MEM && state_d == S_MEM) ? mem_cnt + 1'b1 : '0;
    end
  end

  logic run;
  assign run = ~rst;

  assign pc_ena     = run & (state_q == S_IF);
  assign ir_in      = run & (state_q == S_IF);
  assign decode_ena = run & (state_q == S_IF);
  assign zin        = run & (state_q == S_IF);
  assign zout       = run & (state_q == S_ID);
  assign npc_in     = run & (state_q == S_ID);
  assign alu_ena    = run & (state_q == S_EX);
  assign mdu_start  = run & (state_q == S_EX) & is_mdu;
  assign mem_req    = run & (state_q == S_MEM);
  assign mem_we     = run & (state_q == S_MEM) & is_store;
  assign regfile_w  = run & (state_q == S_WB);
  assign bus_err    = run & mem_timeout;
  assign instr_done = run & (state_d == S_IF);

`ifdef MC_CTRL_EXC_EN
  assign state   = state_q;
  assign exc_ack = run & (state_q == S_EXC);
`else
  logic exc_req_unused;
  assign exc_req_unused = exc_req;
  assign state   = {1'b0, state_q[5:0]};
  assign exc_ack = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm; follows MC_CTRL_EXC_EN if defined for the build.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] decoded_instr;
  logic       mem_ready, mdu_busy, exc_req;
  logic [6:0] state;
  logic pc_ena, ir_in, decode_ena, zin, zout, npc_in, alu_ena, mdu_start;
  logic mem_req, mem_we, regfile_w, bus_err, exc_ack, instr_done;
  logic [13:0] outs;

  int unsigned npass = 0;
  int unsigned nfail = 0;
  int unsigned ntotal = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .NUM_INSTR  (8),
    .JR_MASK    (8'h01),
    .MDU_MASK   (8'h02),
    .LOAD_MASK  (8'h04),
    .STORE_MASK (8'h08),
    .WB_MASK    (8'h36),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst), .decoded_instr(decoded_instr),
    .mem_ready(mem_ready), .mdu_busy(mdu_busy), .exc_req(exc_req),
    .state(state), .pc_ena(pc_ena), .ir_in(ir_in), .decode_ena(decode_ena),
    .zin(zin), .zout(zout), .npc_in(npc_in), .alu_ena(alu_ena),
    .mdu_start(mdu_start), .mem_req(mem_req), .mem_we(mem_we),
    .regfile_w(regfile_w), .bus_err(bus_err), .exc_ack(exc_ack),
    .instr_done(instr_done)
  );

  assign outs = {pc_ena, ir_in, decode_ena, zin, zout, npc_in, alu_ena, mdu_start,
                 mem_req, mem_we, regfile_w, bus_err, exc_ack, instr_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; decoded_instr = '0; mem_ready = 1'b0; mdu_busy = 1'b0; exc_req = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'h01);
    chk("rst_outs", 32'(outs), 32'h0);

    // ALU with writeback
    decoded_instr = 8'h10; rst = 1'b0; #1;
    chk("alu_if_state", 32'(state), 32'h01);
    chk("alu_if_pc", 32'(pc_ena & ir_in & decode_ena & zin), 32'h1);
    chk("alu_if_done", 32'(instr_done), 32'h0);
    tick(); chk("alu_id_state", 32'(state), 32'h02);
    chk("alu_id_zout", 32'(zout & npc_in), 32'h1);
    tick(); chk("alu_ex_state", 32'(state), 32'h04);
    chk("alu_ex_alu", 32'(alu_ena), 32'h1);
    chk("alu_ex_rfw", 32'(regfile_w), 32'h0);
    tick(); chk("alu_wb_state", 32'(state), 32'h10);
    chk("alu_wb_rfw", 32'(regfile_w), 32'h1);
    chk("alu_wb_done", 32'(instr_done), 32'h1);
    tick(); chk("alu_end_state", 32'(state), 32'h01);
    chk("alu_end_rfw", 32'(regfile_w), 32'h0);

    // JR: finishes in ID
    decoded_instr = 8'h01; #1;
    tick(); chk("jr_id_state", 32'(state), 32'h02);
    chk("jr_id_done", 32'(instr_done), 32'h1);
    chk("jr_id_alu", 32'(alu_ena), 32'h0);
    tick(); chk("jr_end_state", 32'(state), 32'h01);
    chk("jr_end_alu", 32'(alu_ena), 32'h0);

    // ALU without writeback: done in EX
    decoded_instr = 8'h40; #1;
    tick(); tick(); chk("nowb_ex_state", 32'(state), 32'h04);
    chk("nowb_ex_done", 32'(instr_done), 32'h1);
    tick(); chk("nowb_end_state", 32'(state), 32'h01);

    // Load, mem_ready in 3rd MEM cycle
    decoded_instr = 8'h04; #1;
    tick(); tick();
    tick(); chk("ld_mem1_state", 32'(state), 32'h08);
    chk("ld_mem1_req", 32'(mem_req), 32'h1);
    chk("ld_mem1_we", 32'(mem_we), 32'h0);
    tick(); chk("ld_mem2_req", 32'(mem_req), 32'h1);
    tick(); mem_ready = 1'b1; #1;
    chk("ld_mem3_state", 32'(state), 32'h08);
    chk("ld_mem3_done", 32'(instr_done), 32'h0);
    chk("ld_mem3_berr", 32'(bus_err), 32'h0);
    tick(); mem_ready = 1'b0; #1;
    chk("ld_wb_state", 32'(state), 32'h10);
    chk("ld_wb_rfw", 32'(regfile_w), 32'h1);
    chk("ld_wb_req", 32'(mem_req), 32'h0);
    tick(); chk("ld_end_state", 32'(state), 32'h01);

    // Store, mem_ready held low: timeout in 4th MEM cycle
    decoded_instr = 8'h08; #1;
    tick(); tick();
    tick(); chk("st_mem1_we", 32'(mem_we & mem_req), 32'h1);
    chk("st_mem1_berr", 32'(bus_err), 32'h0);
    tick(); chk("st_mem2_we", 32'(mem_we), 32'h1);
    tick(); chk("st_mem3_berr", 32'(bus_err), 32'h0);
    tick(); chk("st_mem4_state", 32'(state), 32'h08);
    chk("st_mem4_berr", 32'(bus_err), 32'h1);
    chk("st_mem4_we", 32'(mem_we), 32'h1);
`ifdef MC_CTRL_EXC_EN
    chk("st_mem4_done", 32'(instr_done), 32'h0);
    tick(); chk("st_exc_state", 32'(state), 32'h40);
    chk("st_exc_ack", 32'(exc_ack), 32'h1);
    chk("st_exc_done", 32'(instr_done), 32'h1);
    chk("st_exc_berr", 32'(bus_err), 32'h0);
    tick(); chk("st_end_state", 32'(state), 32'h01);
    chk("st_end_ack", 32'(exc_ack), 32'h0);
`else
    chk("st_mem4_done", 32'(instr_done), 32'h1);
    tick(); chk("st_end_state", 32'(state), 32'h01);
    chk("st_end_ack", 32'(exc_ack), 32'h0);
    chk("st_end_berr", 32'(bus_err), 32'h0);
`endif

    // Store, mem_ready arrives on the timeout cycle: ready wins
    tick(); tick();
    tick(); chk("st2_mem1_state", 32'(state), 32'h08);
    tick(); tick();
    tick(); mem_ready = 1'b1; #1;
    chk("st2_mem4_state", 32'(state), 32'h08);
    chk("st2_mem4_berr", 32'(bus_err), 32'h0);
    chk("st2_mem4_done", 32'(instr_done), 32'h1);
    tick(); mem_ready = 1'b0; #1;
    chk("st2_end_state", 32'(state), 32'h01);

    // MDU with 3 busy cycles in MDUW
    decoded_instr = 8'h02; mdu_busy = 1'b1; #1;
    tick(); tick(); chk("mdu_ex_state", 32'(state), 32'h04);
    chk("mdu_ex_start", 32'(mdu_start), 32'h1);
    tick(); chk("mdu_w1_state", 32'(state), 32'h20);
    chk("mdu_w1_start", 32'(mdu_start), 32'h0);
    tick(); tick(); chk("mdu_w3_state", 32'(state), 32'h20);
    tick(); mdu_busy = 1'b0; #1;
    chk("mdu_w4_state", 32'(state), 32'h20);
    chk("mdu_w4_done", 32'(instr_done), 32'h0);
    tick(); chk("mdu_wb_state", 32'(state), 32'h10);
    chk("mdu_wb_rfw", 32'(regfile_w), 32'h1);
    tick(); chk("mdu_end_state", 32'(state), 32'h01);

    // exc_req sampled in ID
    decoded_instr = 8'h10; exc_req = 1'b1; #1;
    tick();
`ifdef MC_CTRL_EXC_EN
    tick(); exc_req = 1'b0; #1;
    chk("exc_id_state", 32'(state), 32'h40);
    chk("exc_id_ack", 32'(exc_ack), 32'h1);
    tick(); chk("exc_end_state", 32'(state), 32'h01);
`else
    tick(); exc_req = 1'b0; #1;
    chk("exc_ign_state", 32'(state), 32'h04);
    chk("exc_ign_ack", 32'(exc_ack), 32'h0);
    tick(); tick(); chk("exc_ign_end", 32'(state), 32'h01);
`endif

    // rst during a load's second MEM cycle
    decoded_instr = 8'h04; #1;
    tick(); tick(); tick();
    tick(); rst = 1'b1; #1;
    chk("rstm_state", 32'(state), 32'h08);
    chk("rstm_outs", 32'(outs), 32'h0);
    tick(); chk("rstm_next_state", 32'(state), 32'h01);
    chk("rstm_next_outs", 32'(outs), 32'h0);
    rst = 1'b0; mem_ready = 1'b1; #1;
    chk("rstm_if_rfw", 32'(regfile_w), 32'h0);
    chk("rstm_if_pc", 32'(pc_ena), 32'h1);
    tick(); chk("rstm_id_state", 32'(state), 32'h02);
    chk("rstm_id_rfw", 32'(regfile_w), 32'h0);
    tick(); chk("rstm_ex_rfw", 32'(regfile_w), 32'h0);
    mem_ready = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
